nvme_admin_cmd_fifo: RTL and testbench



---
 rtl/nvme_admin_cmd_fifo.sv | 122 ++++++++++++
 tb/tb_nvme_admin_cmd_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nvme_admin_cmd_fifo.sv
// nvme_admin_cmd_fifo
// Single-clock circular buffer for NVMe admin submission/completion entries.
// Registered occupancy and flags, sticky overflow/underflow, and a choice of
// normal (registered q) or show-ahead (q presents the head entry) read mode.
module nvme_admin_cmd_fifo #(
    parameter int WIDTH     = 170,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int SHOWAHEAD = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           data,
    input  logic                       wrreq,
    input  logic                       rdreq,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           q,
    output logic                       rdempty,
    output logic                       wrfull,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     usedw,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] usedw_q, usedw_d;
    logic          rdempty_q, rdempty_d;
    logic          wrfull_q, wrfull_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc;
    logic          rd_acc;

    // Accept decisions use the flags registered before the edge, so a full
    // FIFO turns read+write into read-only and an empty one into write-only.
    always_comb begin
        wr_acc   = wrreq & ~wrfull_q;
        rd_acc   = rdreq & ~rdempty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        usedw_d  = usedw_q;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + CW'(1);
            2'b01:   usedw_d = usedw_q - CW'(1);
            default: usedw_d = usedw_q;
        endcase
        rdempty_d = (usedw_d == '0);
        wrfull_d  = (usedw_d == DEPTH_C);
        afull_d   = (usedw_d >= AF_C);
        // A fresh error wins over a coincident clear.
        ovf_d     = (ovf_q & ~clr_err) | (wrreq & wrfull_q);
        udf_d     = (udf_q & ~clr_err) | (rdreq & rdempty_q);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usedw_q   <= '0;
            rdempty_q <= 1'b1;
            wrfull_q  <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            usedw_q   <= usedw_d;
            rdempty_q <= rdempty_d;
            wrfull_q  <= wrfull_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage array; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // Head entry is presented directly; meaningless while empty.
            assign q = mem_q[rd_ptr_q];
        end else begin : g_normal
            logic [WIDTH-1:0] q_q;

            // Output register loads only on an accepted read and otherwise holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q <= '0;
                end else if (rd_acc) begin
                    q_q <= mem_q[rd_ptr_q];
                end
            end

            assign q = q_q;
        end
    endgenerate

    assign rdempty     = rdempty_q;
    assign wrfull      = wrfull_q;
    assign almost_full = afull_q;
    assign usedw       = usedw_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_nvme_admin_cmd_fifo.sv
// Bench for nvme_admin_cmd_fifo: a normal-mode and a show-ahead instance share
// one stimulus stream and are compared each cycle against a queue-based model.
module tb_nvme_admin_cmd_fifo;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int AF = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data = '0;
    logic         wrreq = 1'b0;
    logic         rdreq = 1'b0;
    logic         clr_err = 1'b0;

    logic [W-1:0] q_n, q_s;
    logic         rdempty_n, wrfull_n, af_n, ovf_n, udf_n;
    logic         rdempty_s, wrfull_s, af_s, ovf_s, udf_s;
    logic [2:0]   usedw_n, usedw_s;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] mdl_qn;
    logic         mdl_ovf;
    logic         mdl_udf;

    always #5 clk = ~clk;

    nvme_admin_cmd_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .SHOWAHEAD(0)) u_norm (
        .clk(clk), .rst_n(rst_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .clr_err(clr_err), .q(q_n), .rdempty(rdempty_n), .wrfull(wrfull_n),
        .almost_full(af_n), .usedw(usedw_n), .overflow(ovf_n), .underflow(udf_n)
    );

    nvme_admin_cmd_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .SHOWAHEAD(1)) u_sa (
        .clk(clk), .rst_n(rst_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .clr_err(clr_err), .q(q_s), .rdempty(rdempty_s), .wrfull(wrfull_s),
        .almost_full(af_s), .usedw(usedw_s), .overflow(ovf_s), .underflow(udf_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        mq.delete();
        mdl_qn  = '0;
        mdl_ovf = 1'b0;
        mdl_udf = 1'b0;
    endfunction

    function automatic void mdl_step(input logic w, input logic r, input logic [W-1:0] d,
                                     input logic c);
        int  n;
        bit  wa, ra, new_ov, new_ud;
        n      = mq.size();
        wa     = w && (n < D);
        ra     = r && (n > 0);
        new_ov = w && (n == D);
        new_ud = r && (n == 0);
        if (ra) mdl_qn = mq.pop_front();
        if (wa) mq.push_back(d);
        mdl_ovf = (mdl_ovf && !c) || new_ov;
        mdl_udf = (mdl_udf && !c) || new_ud;
    endfunction

    task automatic check_all();
        int n;
        n = mq.size();
        chk("n_usedw",   64'(usedw_n),   64'(n));
        chk("n_rdempty", 64'(rdempty_n), 64'(n == 0));
        chk("n_wrfull",  64'(wrfull_n),  64'(n == D));
        chk("n_afull",   64'(af_n),      64'(n >= AF));
        chk("n_ovf",     64'(ovf_n),     64'(mdl_ovf));
        chk("n_udf",     64'(udf_n),     64'(mdl_udf));
        chk("n_q",       64'(q_n),       64'(mdl_qn));
        chk("s_usedw",   64'(usedw_s),   64'(n));
        chk("s_rdempty", 64'(rdempty_s), 64'(n == 0));
        chk("s_wrfull",  64'(wrfull_s),  64'(n == D));
        chk("s_afull",   64'(af_s),      64'(n >= AF));
        chk("s_ovf",     64'(ovf_s),     64'(mdl_ovf));
        chk("s_udf",     64'(udf_s),     64'(mdl_udf));
        if (n > 0) chk("s_q_head", 64'(q_s), 64'(mq[0]));
    endtask

    // One clock: drive inputs, take the edge, advance the model, check 1 ns later.
    task automatic cyc(input logic w, input logic r, input logic [W-1:0] d, input logic c);
        wrreq   = w;
        rdreq   = r;
        data    = d;
        clr_err = c;
        @(posedge clk);
        mdl_step(w, r, d, c);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("rst_usedw",   64'(usedw_n),   64'd0);
        chk("rst_rdempty", 64'(rdempty_n), 64'd1);
        chk("rst_q",       64'(q_n),       64'd0);
        check_all();
        @(negedge clk);
        rst_n   = 1'b1;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [W-1:0] fill_vals [4];
        int           bias;
        fill_vals[0] = 16'h000A;
        fill_vals[1] = 16'h000B;
        fill_vals[2] = 16'h000C;
        fill_vals[3] = 16'h000D;

        mdl_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // fill to full
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, fill_vals[i], 1'b0);
            chk("fill_usedw", 64'(usedw_n), 64'(i + 1));
            chk("fill_afull", 64'(af_n), 64'(i >= 2));
        end
        chk("fill_full", 64'(wrfull_n), 64'd1);

        // overflow then drain
        cyc(1'b1, 1'b0, 16'h000E, 1'b0);
        chk("ovf_usedw", 64'(usedw_n), 64'd4);
        chk("ovf_flag",  64'(ovf_n),   64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, '0, 1'b0);
            chk("drain_q", 64'(q_n), 64'(fill_vals[i]));
        end
        chk("drain_empty", 64'(rdempty_n), 64'd1);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("udf_flag", 64'(udf_n), 64'd1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("clr_ovf", 64'(ovf_n), 64'd0);
        chk("clr_udf", 64'(udf_n), 64'd0);

        // steady read+write at usedw=2, pointers wrap twice
        cyc(1'b1, 1'b0, 16'h0010, 1'b0);
        cyc(1'b1, 1'b0, 16'h0011, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, W'(16'h0012 + i), 1'b0);
            chk("rw_usedw", 64'(usedw_n), 64'd2);
            chk("rw_order", 64'(q_n), 64'(16'h0010 + i));
        end

        // full with read+write: read only
        cyc(1'b1, 1'b0, 16'h0020, 1'b0);
        cyc(1'b1, 1'b0, 16'h0021, 1'b0);
        cyc(1'b1, 1'b1, 16'h0022, 1'b0);
        chk("full_rw_usedw", 64'(usedw_n), 64'd3);
        chk("full_rw_ovf",   64'(ovf_n),   64'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, 1'b1);
        // empty with read+write: write only
        cyc(1'b1, 1'b1, 16'h0030, 1'b0);
        chk("empty_rw_usedw", 64'(usedw_n), 64'd1);
        chk("empty_rw_udf",   64'(udf_n),   64'd1);

        // show-ahead versus normal from a clean reset
        async_reset();
        cyc(1'b1, 1'b0, 16'h0055, 1'b0);
        chk("sa_q_visible", 64'(q_s), 64'h55);
        chk("nm_q_still0",  64'(q_n), 64'h0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("sa_q_hold",    64'(q_s), 64'h55);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("sa_empty",     64'(rdempty_s), 64'd1);
        chk("nm_q_55",      64'(q_n), 64'h55);

        // reset in the middle of a burst
        cyc(1'b1, 1'b0, 16'h0101, 1'b0);
        cyc(1'b1, 1'b0, 16'h0102, 1'b0);
        cyc(1'b1, 1'b0, 16'h0103, 1'b0);
        chk("burst_usedw", 64'(usedw_n), 64'd3);
        async_reset();
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("post_rst_udf", 64'(udf_n), 64'd1);
        chk("post_rst_q",   64'(q_n),   64'd0);

        // randomized traffic with shifting write/read bias
        for (int i = 0; i < 800; i++) begin
            if ((i % 100) == 0) bias = $urandom_range(20, 80);
            cyc(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias - 10),
                W'($urandom), ($urandom_range(0, 15) == 0));
            if (i == 400) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
